// File: rtl/cbus_sram_burst_bridge_pkg.sv
// cbus_sram_burst_bridge_pkg: CBus request/response types, burst/size codes and bridge state shared by the bridge.
package cbus_sram_burst_bridge_pkg;
  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP = 2'd2;
  localparam logic [2:0] MSIZE1 = 3'd0;
  localparam logic [2:0] MSIZE2 = 3'd1;
  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [2:0] MSIZE8 = 3'd3;
  typedef struct packed {
    logic valid;
    logic is_write;
    logic [2:0] size;
    logic [63:0] addr;
    logic [7:0] strobe;
    logic [63:0] data;
    logic [7:0] len;
    logic [1:0] burst;
  } cbus_req_t;
  typedef struct packed {
    logic ready;
    logic last;
    logic [63:0] data;
  } cbus_resp_t;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} bridge_state_t;
  typedef enum logic [1:0] {SEL_SRAM, SEL_MTIME, SEL_ZERO} rsel_t;
  // One in-flight read beat: its data source is decided at issue, not at return.
  typedef struct packed {
    logic valid;
    logic last;
    logic err;
    rsel_t sel;
    logic [63:0] sample;
  } pipe_t;
  function automatic logic [63:0] expand_strobe(input logic [7:0] s);
    logic [63:0] m;
    for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{s[k]}};
    return m;
  endfunction
endpackage

// File: rtl/cbus_burst_addr_gen.sv
// cbus_burst_addr_gen: beat address for FIXED/INCR/WRAP bursts and burst/size/len legality.
module cbus_burst_addr_gen
  import cbus_sram_burst_bridge_pkg::*;
(
  input  logic [63:0] addr,
  input  logic [7:0]  len,
  input  logic [1:0]  burst,
  input  logic [2:0]  size,
  input  logic [7:0]  beat,
  output logic [63:0] a_i,
  output logic        legal
);
  logic [63:0] mask, incr;
  logic wrap_len_ok;
  always_comb begin
    mask = (({56'd0, len} + 64'd1) << 3) - 64'd1;
    incr = addr + {53'd0, beat, 3'd0};
    wrap_len_ok = len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15;
    a_i = burst == AXI_BURST_FIXED ? addr :
          burst == AXI_BURST_WRAP ? (addr & ~mask) | (incr & mask) : incr;
    legal = burst == AXI_BURST_FIXED ||
            (size == MSIZE8 && (burst == AXI_BURST_INCR || (burst == AXI_BURST_WRAP && wrap_len_ok)));
  end
endmodule

// File: rtl/cbus_sram_burst_bridge.sv
// cbus_sram_burst_bridge: splits a CBus burst into per-beat SRAM accesses with MMIO intercepts,
// range/legality faulting and a configurable-latency read return pipe.
module cbus_sram_burst_bridge
  import cbus_sram_burst_bridge_pkg::*;
#(
  parameter int          IDX_W      = 26,
  parameter logic [63:0] MEM_BASE   = 64'h8000_0000,
  parameter int          SRAM_LAT   = 1,
  parameter logic [63:0] MTIME_ADDR = 64'h3800_bff8,
  parameter logic [63:0] ZERO_ADDR  = 64'h4060_0008
) (
  input  logic        clk,
  input  logic        resetn,
  input  cbus_req_t   oreq,
  output cbus_resp_t  oresp,
  output logic [63:0] rIdx,
  input  logic [63:0] rdata,
  output logic [63:0] wIdx,
  output logic [63:0] wdata,
  output logic [63:0] wmask,
  output logic        wen,
  output logic        en,
  output logic        err
);
  bridge_state_t state, state_nxt;
  logic [63:0] addr_q, mtime, a_i, off, idx;
  logic [7:0] len_q, beat;
  logic [1:0] burst_q;
  logic [2:0] size_q;
  logic fault_q, legal, in_range, is_mtime, is_zero, beat_fault, issue, wr, last_issue, sram_ok;
  pipe_t pipe [SRAM_LAT];
  pipe_t pipe_in, pipe_out;

  cbus_burst_addr_gen u_addr_gen (
    .addr(addr_q), .len(len_q), .burst(burst_q), .size(size_q), .beat(beat),
    .a_i(a_i), .legal(legal)
  );

  always_comb begin
    off = a_i - MEM_BASE;
    idx = 64'(off[IDX_W+2:3]);
    in_range = (off >> (IDX_W + 3)) == 64'd0;
    is_mtime = a_i == MTIME_ADDR;
    is_zero = a_i == ZERO_ADDR;
    beat_fault = !legal || (!is_mtime && !is_zero && !in_range);
    wr = state == WRITE;
    issue = wr || state == READ;
    last_issue = beat == len_q;
    sram_ok = issue && !beat_fault && !is_mtime && !is_zero;
    pipe_out = pipe[SRAM_LAT-1];
    pipe_in = '{valid: state == READ, last: last_issue, err: last_issue && (fault_q || beat_fault),
                sel: (beat_fault || is_zero) ? SEL_ZERO : is_mtime ? SEL_MTIME : SEL_SRAM,
                sample: mtime};
  end

  assign en = sram_ok;
  assign wen = sram_ok && wr;
  assign rIdx = (sram_ok && !wr) ? idx : '0;
  assign wIdx = wen ? idx : '0;
  assign wdata = wr ? oreq.data : '0;
  assign wmask = wr ? expand_strobe(oreq.strobe) : '0;
  assign oresp.ready = wr || pipe_out.valid;
  assign oresp.last = wr ? last_issue : pipe_out.valid && pipe_out.last;
  assign oresp.data = !pipe_out.valid ? '0 : pipe_out.sel == SEL_SRAM ? rdata :
                      pipe_out.sel == SEL_MTIME ? pipe_out.sample : '0;
  assign err = wr ? last_issue && (fault_q || beat_fault) : pipe_out.valid && pipe_out.err;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = !oreq.valid ? IDLE : oreq.is_write ? WRITE : READ;
      WRITE: state_nxt = last_issue ? IDLE : WRITE;
      READ: state_nxt = last_issue ? DRAIN : READ;
      DRAIN: state_nxt = (pipe_out.valid && pipe_out.last) ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      burst_q <= '0;
      size_q <= '0;
      beat <= '0;
      fault_q <= 1'b0;
      mtime <= '0;
    end else begin
      state <= state_nxt;
      mtime <= mtime + 64'd1;
      if (state == IDLE && oreq.valid) begin
        addr_q <= oreq.addr;
        len_q <= oreq.len;
        burst_q <= oreq.burst;
        size_q <= oreq.size;
        beat <= '0;
        fault_q <= 1'b0;
      end else if (issue) begin
        beat <= beat + 8'd1;
        fault_q <= fault_q || beat_fault;
      end
    end
  end

  // Reset empties the pipe so in-flight read data is never returned.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SRAM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= pipe_in;
      for (int i = 1; i < SRAM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  a_valid_held: assert property (@(posedge clk) disable iff (!resetn) state != IDLE |-> oreq.valid);
endmodule
